// File: rtl/axi_lite_pkg.sv
// Shared types for the AXI4-Lite memory responder.
//   resp_t     : AXI response codes used by this block (OKAY, SLVERR)
//   wr_state_t : write channel FSM states
//   rd_state_t : read channel FSM states
package axi_lite_pkg;

  typedef enum logic [1:0] {
    RespOkay   = 2'b00,
    RespSlverr = 2'b10
  } resp_t;

  typedef enum logic [1:0] {
    WIdle,
    WWait,
    WResp
  } wr_state_t;

  typedef enum logic [1:0] {
    RIdle,
    RWait,
    RResp
  } rd_state_t;

endpackage

// File: rtl/axi_lite_resp_timer.sv
// Response delay timer, one per channel.
//   clk, rst : clock and asynchronous active-high reset
//   load     : reload the counter with delay (FSM entering its wait state)
//   count    : decrement while the FSM sits in its wait state
//   delay    : number of wait cycles, 1..15 when used
//   done     : high during the last wait cycle
module axi_lite_resp_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       count,
  input  logic [3:0] delay,
  output logic       done
);

  logic [3:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= 4'd0;
    end else if (load) begin
      cnt_q <= delay;
    end else if (count && (cnt_q != 4'd0)) begin
      cnt_q <= cnt_q - 4'd1;
    end
  end

  // Wait state is left on the edge where the counter shows 1, giving exactly
  // 'delay' edges spent in the wait state.
  assign done = (cnt_q == 4'd1);

endmodule

// File: rtl/axi_lite_mem_slave.sv
// AXI4-Lite memory responder.
//   ACLK/ARESET        : clock, asynchronous active-high reset
//   AW*/W*/B*          : write channel; AW and W captured independently, one write in flight
//   AR*/R*             : read channel; one read in flight, runs concurrently with writes
// Byte-strobed word memory of MEM_DEPTH words starting at BASE_ADDR; accesses outside the
// window answer SLVERR. BVALID/RVALID appear RESP_DELAY cycles after the request completes.
module axi_lite_mem_slave
  import axi_lite_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           MEM_DEPTH  = 256,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter int unsigned           RESP_DELAY = 0
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
  input  logic [ADDR_WIDTH-1:0]   AWADDR,
  input  logic [2:0]              AWPROT,
  input  logic                    AWVALID,
  output logic                    AWREADY,
  input  logic [DATA_WIDTH-1:0]   WDATA,
  input  logic [DATA_WIDTH/8-1:0] WSTRB,
  input  logic                    WVALID,
  output logic                    WREADY,
  output logic [1:0]              BRESP,
  output logic                    BVALID,
  input  logic                    BREADY,
  input  logic [ADDR_WIDTH-1:0]   ARADDR,
  input  logic [2:0]              ARPROT,
  input  logic                    ARVALID,
  output logic                    ARREADY,
  output logic [DATA_WIDTH-1:0]   RDATA,
  output logic [1:0]              RRESP,
  output logic                    RVALID,
  output logic                    RLAST,
  input  logic                    RREADY
);

  localparam int unsigned StrbW    = DATA_WIDTH / 8;
  localparam int unsigned OffW     = $clog2(StrbW);
  localparam int unsigned IdxW     = $clog2(MEM_DEPTH);
  localparam logic [3:0]  DelayCnt = 4'(RESP_DELAY);
  localparam logic        HasDelay = (RESP_DELAY != 0);

  function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] addr);
    logic [ADDR_WIDTH-1:0] word;
    word = (addr - BASE_ADDR) >> OffW;
    return (addr >= BASE_ADDR) && (word < ADDR_WIDTH'(MEM_DEPTH));
  endfunction

  function automatic logic [IdxW-1:0] addr_idx(input logic [ADDR_WIDTH-1:0] addr);
    return IdxW'((addr - BASE_ADDR) >> OffW);
  endfunction

  logic unused_prot;
  assign unused_prot = ^{AWPROT, ARPROT};

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  // ---------------------------------------------------------------- write channel
  wr_state_t             wr_state_q, wr_state_d;
  logic                  aw_held_q, w_held_q;
  logic [ADDR_WIDTH-1:0] awaddr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [StrbW-1:0]      wstrb_q;
  logic                  awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
  resp_t                 bresp_q;

  logic                  aw_hs, w_hs, aw_have, w_have, wr_commit, wr_ok, wr_done;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [StrbW-1:0]      wr_strb;
  logic [IdxW-1:0]       wr_idx;

  // Readies are only ever high in WIdle, so a handshake implies WIdle.
  assign aw_hs     = AWVALID & awready_q;
  assign w_hs      = WVALID & wready_q;
  assign aw_have   = aw_held_q | aw_hs;
  assign w_have    = w_held_q | w_hs;
  assign wr_commit = aw_have & w_have;
  // Use the live bus when the handshake happens on the commit edge itself.
  assign wr_addr   = aw_hs ? AWADDR : awaddr_q;
  assign wr_data   = w_hs ? WDATA : wdata_q;
  assign wr_strb   = w_hs ? WSTRB : wstrb_q;
  assign wr_ok     = addr_ok(wr_addr);
  assign wr_idx    = addr_idx(wr_addr);

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      wr_state_q <= WIdle;
    end else begin
      wr_state_q <= wr_state_d;
    end
  end

  always_comb begin
    wr_state_d = wr_state_q;
    unique case (wr_state_q)
      WIdle:   if (wr_commit) wr_state_d = HasDelay ? WWait : WResp;
      WWait:   if (wr_done) wr_state_d = WResp;
      WResp:   if (BREADY) wr_state_d = WIdle;
      default: wr_state_d = WIdle;
    endcase
  end

  always_comb begin
    awready_d = (wr_state_d == WIdle) && !aw_have;
    wready_d  = (wr_state_d == WIdle) && !w_have;
    bvalid_d  = (wr_state_d == WResp);
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RespOkay;
    end else begin
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      if (wr_commit) begin
        aw_held_q <= 1'b0;
        w_held_q  <= 1'b0;
        bresp_q   <= wr_ok ? RespOkay : RespSlverr;
      end else begin
        if (aw_hs) begin
          aw_held_q <= 1'b1;
          awaddr_q  <= AWADDR;
        end
        if (w_hs) begin
          w_held_q <= 1'b1;
          wdata_q  <= WDATA;
          wstrb_q  <= WSTRB;
        end
      end
    end
  end

  axi_lite_resp_timer u_wr_timer (
    .clk   (ACLK),
    .rst   (ARESET),
    .load  (wr_commit && HasDelay),
    .count (wr_state_q == WWait),
    .delay (DelayCnt),
    .done  (wr_done)
  );

  always_ff @(posedge ACLK) begin
    if (wr_commit && wr_ok) begin
      for (int b = 0; b < StrbW; b++) begin
        if (wr_strb[b]) mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  assign AWREADY = awready_q;
  assign WREADY  = wready_q;
  assign BVALID  = bvalid_q;
  assign BRESP   = bresp_q;

  // ---------------------------------------------------------------- read channel
  rd_state_t             rd_state_q, rd_state_d;
  logic [ADDR_WIDTH-1:0] araddr_q, rd_addr;
  logic                  arready_q, arready_d, rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0] rdata_q;
  resp_t                 rresp_q;
  logic                  ar_hs, rd_capture, rd_ok, rd_done;

  assign ar_hs      = ARVALID & arready_q;
  assign rd_addr    = ar_hs ? ARADDR : araddr_q;
  assign rd_ok      = addr_ok(rd_addr);
  assign rd_capture = (rd_state_d == RResp) && (rd_state_q != RResp);

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      rd_state_q <= RIdle;
    end else begin
      rd_state_q <= rd_state_d;
    end
  end

  always_comb begin
    rd_state_d = rd_state_q;
    unique case (rd_state_q)
      RIdle:   if (ar_hs) rd_state_d = HasDelay ? RWait : RResp;
      RWait:   if (rd_done) rd_state_d = RResp;
      RResp:   if (RREADY) rd_state_d = RIdle;
      default: rd_state_d = RIdle;
    endcase
  end

  always_comb begin
    arready_d = (rd_state_d == RIdle);
    rvalid_d  = (rd_state_d == RResp);
  end

  // Memory read uses the pre-edge array contents, so a same-edge write to the
  // same word is not visible to this capture.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      araddr_q  <= '0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RespOkay;
    end else begin
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      if (ar_hs) araddr_q <= ARADDR;
      if (rd_capture) begin
        rdata_q <= rd_ok ? mem[addr_idx(rd_addr)] : '0;
        rresp_q <= rd_ok ? RespOkay : RespSlverr;
      end else if ((rd_state_q == RResp) && RREADY) begin
        rdata_q <= '0;
        rresp_q <= RespOkay;
      end
    end
  end

  axi_lite_resp_timer u_rd_timer (
    .clk   (ACLK),
    .rst   (ARESET),
    .load  (ar_hs && HasDelay),
    .count (rd_state_q == RWait),
    .delay (DelayCnt),
    .done  (rd_done)
  );

  assign ARREADY = arready_q;
  assign RVALID  = rvalid_q;
  assign RLAST   = rvalid_q;
  assign RDATA   = rdata_q;
  assign RRESP   = rresp_q;

endmodule

// File: tb/tb_axi_lite_mem_slave.sv
// Directed bench for axi_lite_mem_slave. Two instances share all inputs:
// dut0 with RESP_DELAY=0 and dut3 with RESP_DELAY=3.
module tb_axi_lite_mem_slave;

  logic        aclk, areset;
  logic [31:0] awaddr, wdata, araddr;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wstrb;
  logic        awvalid, wvalid, bready, arvalid, rready;

  logic        awready0, wready0, bvalid0, arready0, rvalid0, rlast0;
  logic [1:0]  bresp0, rresp0;
  logic [31:0] rdata0;
  logic        awready3, wready3, bvalid3, arready3, rvalid3, rlast3;
  logic [1:0]  bresp3, rresp3;
  logic [31:0] rdata3;

  int n_checks = 0;
  int n_bad    = 0;

  axi_lite_mem_slave #(.RESP_DELAY(0)) dut0 (
    .ACLK(aclk), .ARESET(areset),
    .AWADDR(awaddr), .AWPROT(awprot), .AWVALID(awvalid), .AWREADY(awready0),
    .WDATA(wdata), .WSTRB(wstrb), .WVALID(wvalid), .WREADY(wready0),
    .BRESP(bresp0), .BVALID(bvalid0), .BREADY(bready),
    .ARADDR(araddr), .ARPROT(arprot), .ARVALID(arvalid), .ARREADY(arready0),
    .RDATA(rdata0), .RRESP(rresp0), .RVALID(rvalid0), .RLAST(rlast0), .RREADY(rready)
  );

  axi_lite_mem_slave #(.RESP_DELAY(3)) dut3 (
    .ACLK(aclk), .ARESET(areset),
    .AWADDR(awaddr), .AWPROT(awprot), .AWVALID(awvalid), .AWREADY(awready3),
    .WDATA(wdata), .WSTRB(wstrb), .WVALID(wvalid), .WREADY(wready3),
    .BRESP(bresp3), .BVALID(bvalid3), .BREADY(bready),
    .ARADDR(araddr), .ARPROT(arprot), .ARVALID(arvalid), .ARREADY(arready3),
    .RDATA(rdata3), .RRESP(rresp3), .RVALID(rvalid3), .RLAST(rlast3), .RREADY(rready)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic wr(input bit sel, input logic [31:0] addr, input logic [31:0] data,
                    input logic [3:0] strb, output logic [1:0] resp);
    int n;
    awaddr = addr; wdata = data; wstrb = strb;
    awvalid = 1'b1; wvalid = 1'b1;
    step();
    awvalid = 1'b0; wvalid = 1'b0;
    n = 0;
    while (!(sel ? bvalid3 : bvalid0) && n < 20) begin
      step();
      n++;
    end
    check_eq("wr_bvalid", 32'(sel ? bvalid3 : bvalid0), 32'd1);
    resp = sel ? bresp3 : bresp0;
    bready = 1'b1;
    step();
    bready = 1'b0;
  endtask

  task automatic rd(input bit sel, input logic [31:0] addr, output logic [31:0] data,
                    output logic [1:0] resp);
    int n;
    araddr = addr; arvalid = 1'b1;
    step();
    arvalid = 1'b0;
    n = 0;
    while (!(sel ? rvalid3 : rvalid0) && n < 20) begin
      step();
      n++;
    end
    check_eq("rd_rvalid", 32'(sel ? rvalid3 : rvalid0), 32'd1);
    check_eq("rd_rlast", 32'(sel ? rlast3 : rlast0), 32'd1);
    data = sel ? rdata3 : rdata0;
    resp = sel ? rresp3 : rresp0;
    rready = 1'b1;
    step();
    rready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  resp;
    logic [31:0] data;

    areset = 1'b1;
    awaddr = '0; wdata = '0; araddr = '0; awprot = '0; arprot = '0; wstrb = '0;
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
    repeat (3) step();
    check_eq("rst_awready", 32'(awready0), 32'd0);
    check_eq("rst_arready", 32'(arready0), 32'd0);
    check_eq("rst_bvalid", 32'(bvalid0), 32'd0);
    check_eq("rst_rvalid", 32'(rvalid0), 32'd0);
    areset = 1'b0;
    #1;
    check_eq("rdy_not_early", 32'(awready0), 32'd0);
    step();
    check_eq("rdy_awready", 32'(awready0), 32'd1);
    check_eq("rdy_wready", 32'(wready0), 32'd1);
    check_eq("rdy_arready", 32'(arready0), 32'd1);

    // 1: write + read, zero delay
    awaddr = 32'h10; wdata = 32'hCAFE_BABE; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    step();
    awvalid = 1'b0; wvalid = 1'b0;
    check_eq("t1_bvalid", 32'(bvalid0), 32'd1);
    check_eq("t1_bresp", 32'(bresp0), 32'd0);
    check_eq("t1_wready_low", 32'(wready0), 32'd0);
    bready = 1'b1;
    step();
    bready = 1'b0;
    check_eq("t1_bvalid_clr", 32'(bvalid0), 32'd0);
    check_eq("t1_awready_back", 32'(awready0), 32'd1);
    araddr = 32'h10; arvalid = 1'b1;
    step();
    arvalid = 1'b0;
    check_eq("t1_rvalid", 32'(rvalid0), 32'd1);
    check_eq("t1_rdata", rdata0, 32'hCAFE_BABE);
    check_eq("t1_rlast", 32'(rlast0), 32'd1);
    check_eq("t1_rresp", 32'(rresp0), 32'd0);
    rready = 1'b1;
    step();
    rready = 1'b0;
    check_eq("t1_rlast_clr", 32'(rlast0), 32'd0);

    // Same-edge write commit and read capture to one word: read sees old data
    awaddr = 32'h10; wdata = 32'h1234_5678; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    araddr = 32'h10; arvalid = 1'b1;
    step();
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    check_eq("haz_rdata_old", rdata0, 32'hCAFE_BABE);
    check_eq("haz_bvalid", 32'(bvalid0), 32'd1);
    bready = 1'b1; rready = 1'b1;
    step();
    bready = 1'b0; rready = 1'b0;
    rd(1'b0, 32'h10, data, resp);
    check_eq("haz_rdata_new", data, 32'h1234_5678);

    // 2: byte strobes
    wr(1'b0, 32'h20, 32'h1122_3344, 4'hF, resp);
    wr(1'b0, 32'h20, 32'hAABB_CCDD, 4'b0101, resp);
    rd(1'b0, 32'h20, data, resp);
    check_eq("t2_strobe", data, 32'h11BB_33DD);

    // 3: W before AW
    wdata = 32'h5555_AAAA; wstrb = 4'hF; wvalid = 1'b1;
    step();
    wvalid = 1'b0;
    check_eq("t3_wready_drop", 32'(wready0), 32'd0);
    check_eq("t3_awready_stay", 32'(awready0), 32'd1);
    step();
    step();
    check_eq("t3_no_early_b", 32'(bvalid0), 32'd0);
    awaddr = 32'h30; awvalid = 1'b1;
    step();
    awvalid = 1'b0;
    check_eq("t3_bvalid", 32'(bvalid0), 32'd1);
    bready = 1'b1;
    step();
    bready = 1'b0;
    rd(1'b0, 32'h30, data, resp);
    check_eq("t3_rdata", data, 32'h5555_AAAA);

    // 5: out of range
    wr(1'b0, 32'h0, 32'h0123_4567, 4'hF, resp);
    check_eq("t5_w0_okay", 32'(resp), 32'd0);
    wr(1'b0, 32'h400, 32'hDEAD_BEEF, 4'hF, resp);
    check_eq("t5_bresp_err", 32'(resp), 32'd2);
    rd(1'b0, 32'h0, data, resp);
    check_eq("t5_mem_unchanged", data, 32'h0123_4567);
    rd(1'b0, 32'h400, data, resp);
    check_eq("t5_rresp_err", 32'(resp), 32'd2);
    check_eq("t5_rdata_zero", data, 32'h0);
    wr(1'b0, 32'h3FC, 32'h89AB_CDEF, 4'hF, resp);
    check_eq("t5_top_okay", 32'(resp), 32'd0);
    rd(1'b0, 32'h3FC, data, resp);
    check_eq("t5_top_rdata", data, 32'h89AB_CDEF);

    // 4: backpressure on the delay-3 instance
    areset = 1'b1;
    step();
    areset = 1'b0;
    step();
    wr(1'b1, 32'h40, 32'h0BAD_F00D, 4'hF, resp);
    check_eq("t4_pre_okay", 32'(resp), 32'd0);
    awaddr = 32'h44; wdata = 32'h600D_CAFE; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    araddr = 32'h40; arvalid = 1'b1;
    step();
    wvalid = 1'b0;
    awaddr = 32'h48; araddr = 32'h48;
    for (int i = 0; i < 3; i++) begin
      check_eq("t4_b_early", 32'(bvalid3), 32'd0);
      check_eq("t4_r_early", 32'(rvalid3), 32'd0);
      step();
    end
    for (int i = 0; i < 5; i++) begin
      check_eq("t4_bvalid_hold", 32'(bvalid3), 32'd1);
      check_eq("t4_bresp_hold", 32'(bresp3), 32'd0);
      check_eq("t4_rvalid_hold", 32'(rvalid3), 32'd1);
      check_eq("t4_rdata_hold", rdata3, 32'h0BAD_F00D);
      check_eq("t4_no_aw", 32'(awready3), 32'd0);
      check_eq("t4_no_ar", 32'(arready3), 32'd0);
      step();
    end
    bready = 1'b1; rready = 1'b1; awvalid = 1'b0; arvalid = 1'b0;
    step();
    bready = 1'b0; rready = 1'b0;
    check_eq("t4_bvalid_clr", 32'(bvalid3), 32'd0);
    check_eq("t4_rvalid_clr", 32'(rvalid3), 32'd0);
    check_eq("t4_arready_back", 32'(arready3), 32'd1);
    rd(1'b1, 32'h44, data, resp);
    check_eq("t4_rdata_44", data, 32'h600D_CAFE);

    // 6: reset during R_WAIT
    araddr = 32'h40; arvalid = 1'b1;
    step();
    arvalid = 1'b0;
    step();
    #2 areset = 1'b1;
    #1;
    check_eq("t6_async_awready", 32'(awready3), 32'd0);
    check_eq("t6_async_rvalid", 32'(rvalid3), 32'd0);
    #1 areset = 1'b0;
    step();
    check_eq("t6_arready_first", 32'(arready3), 32'd1);
    for (int i = 0; i < 5; i++) begin
      check_eq("t6_rvalid_dropped", 32'(rvalid3), 32'd0);
      step();
    end
    rd(1'b1, 32'h40, data, resp);
    check_eq("t6_rdata", data, 32'h0BAD_F00D);
    check_eq("t6_rresp", 32'(resp), 32'd0);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
